uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Serial receiver for the Patmos UART pin pair (iUartPins_rxd side); counterpart of the TX path.
//  Receives 8N1 frames (8E1 with parity option) using 16x oversampling and pushes good bytes into a small FIFO.
//  The processor I/O device drains the FIFO through a valid/ready handshake.
//  Sits between the board-level rxd pin and the UART I/O device.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE   115200    line rate, bit/s; tick divider = CLK_FREQ/(BAUD_RATE*16), integer division, minimum 1
//  FIFO_DEPTH  4         receive FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1  system clock; all logic on its rising edge
//  reset      in   1  synchronous, active-high reset
//  rxd        in   1  asynchronous serial input; idle high
//  rx_data    out  8  FIFO head byte; valid only while rx_valid=1
//  rx_valid   out  1  FIFO not empty
//  rx_ready   in   1  consumer pops the head when rx_valid & rx_ready
//  overrun    out  1  one-cycle pulse: a good byte was dropped because the FIFO was full
//  frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity mismatch when enabled)
// BEHAVIOUR
//  - Reset: rx_valid=0, rx_data=0, overrun=0, frame_err=0. FIFO is emptied, FSM returns to IDLE, sync FFs and rxd_prev are set to 1.
//    Reset mid-frame abandons the partial byte silently.
//  - Input path: 2-FF synchronizer on rxd gives rxs (2-cycle latency). All sampling uses rxs.
//  - Tick generator: counter free-runs only outside IDLE and restarts at 0 on entry to START. tick = 1 cycle per divider period.
//  - FSM:
//    IDLE: a falling edge on rxs (prev 1, now 0) moves to START.
//    START: at tick 8, sample rxs. If 1, it was a glitch: go to IDLE, no error. If 0, go to DATA with bit index 0 and tick count 0.
//    DATA: every 16th tick, sample rxs into bit[idx], LSB first. After idx 7, go to STOP (PARITY when the option is enabled).
//    PARITY: sample at the 16th tick, compare, go to STOP.
//    STOP: sample at the 16th tick. Sample 1 and no parity error -> push byte, go to IDLE.
//      Otherwise pulse frame_err, discard the byte, go to BREAK.
//    BREAK: wait until rxs=1, then go to IDLE (a held-low line produces exactly one frame_err).
//  - Sample point is the mid-bit (8 ticks after the start edge plus 16n).
//  - Push latency: the byte is visible on rx_valid/rx_data on the cycle after the stop-bit sample.
//  - FIFO: count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH. rx_data is the head entry (first-word fall-through).
//  - Simultaneous push and pop: both take effect and count is unchanged. This holds when full, so no overrun occurs in that case.
//  - Push when full with no pop: the byte is dropped, overrun pulses 1 cycle, FIFO contents are untouched.
//  - Pop when empty is ignored.
//  - overrun and frame_err are mutually exclusive per frame. Neither is sticky.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is start + 8 data + 1 even-parity bit + stop.
//    Parity error is set when the XOR of the 8 data bits and the parity bit is 1.
//    A parity error is reported through frame_err; the byte is discarded and the FSM goes to BREAK only if stop=0, otherwise to IDLE.
//  UART_RX_PARITY_EN undefined: 8N1 frame; the PARITY state and its logic are not generated.
// TESTING
//  (Bench uses CLK_FREQ=16000000, BAUD_RATE=1000000, so divider=1 and 1 bit = 16 clk.)
//  1. Send 0xA5 8N1 with rx_ready=1 -> rx_valid high for 1 cycle with rx_data=0xA5; frame_err=0, overrun=0.
//  2. Send 0x01,0x02,0x03,0x04,0x05 with rx_ready=0 (DEPTH=4) -> one overrun pulse on the 5th byte.
//     Then raise rx_ready -> pops 0x01..0x04 in order, then rx_valid=0.
//  3. Send 0x3C with stop bit forced 0 and the line held low for 40 bits -> exactly one frame_err pulse, no push.
//     On line release, a following 0x55 is received correctly.
//  4. Pulse rxd low for 4 clk -> no push, no frame_err, FSM back in IDLE.
//  5. Assert reset at DATA bit 4 of 0xFF -> no push after reset. The next frame 0x81 is received as 0x81.
//  6. With UART_RX_PARITY_EN: send 0x07 with parity=1 -> byte accepted.
//     Send 0x07 with parity=0 -> frame_err pulse, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a small FWFT FIFO.
// Receives 8N1 frames from the rxd pin. Good bytes are pushed into the FIFO
// and drained by the I/O device through a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit, 8E1).
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overrun,
   output logic       frame_err
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t           state;
   logic             rx_meta, rxs, rxd_prev;
   logic [DIV_W-1:0] div_cnt;
   logic             tick, bit_done;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             par_err;
   logic             push, pop, push_ok, full;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;

   // Two-flop synchronizer on the asynchronous pin plus edge-detect history.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rx_meta  <= rxd;
         rxs      <= rx_meta;
         rxd_prev <= rxs;
      end
   end

   // Baud tick divider: held at zero in IDLE so each frame starts phase-aligned.
   always_ff @(posedge clk) begin
      if (reset || state == ST_IDLE)
         div_cnt <= '0;
      else if (div_cnt == DIV_W'(DIV - 1))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   assign tick     = (state != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));
   assign bit_done = tick && (tick_cnt == 4'd15);

   // Frame FSM: start validation at mid-bit, then one sample per 16 ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rxd_prev && !rxs) begin
                  state    <= ST_START;
                  tick_cnt <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tick_cnt == 4'd7) begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     state    <= rxs ? ST_IDLE : ST_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) tick_cnt <= tick_cnt + 4'd1;
               if (bit_done) begin
                  shift_reg <= {rxs, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (tick) tick_cnt <= tick_cnt + 4'd1;
               if (bit_done) begin
                  par_err <= (^shift_reg) ^ rxs;
                  state   <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick) tick_cnt <= tick_cnt + 4'd1;
               if (bit_done) begin
                  if (rxs && !par_err) begin
                     state <= ST_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= rxs ? ST_IDLE : ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rxs) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign par_err = 1'b0;
`endif

   // The good-byte push is combinational so the FIFO captures it on the stop-sample edge.
   assign push     = (state == ST_STOP) && bit_done && rxs && !par_err;
   assign rx_valid = (count != '0);
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign pop      = rx_valid && rx_ready;
   assign push_ok  = push && (!full || pop);
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

   // FIFO storage write port.
   // NOTE: the storage array has no reset; emptiness is tracked by count, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shift_reg;
   end

   // FIFO pointers, occupancy and the overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at 16 clk per bit.
// Build with UART_RX_PARITY_EN defined to add the even-parity scenario.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int BIT_CLKS = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic       frame_err;

   int         total = 0;
   int         bad   = 0;
   int         ovr_cnt  = 0;
   int         ferr_cnt = 0;
   logic [7:0] popq [$];

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLK_FREQ   (16000000),
      .BAUD_RATE  (1000000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   // Event monitor: counts error pulses and records every popped byte.
   always @(negedge clk) begin
      if (overrun === 1'b1)   ovr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) popq.push_back(rx_data);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge; leaves rxd at the stop level.
   task automatic send_frame(input logic [7:0] d, input logic stop_val);
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_clks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rxd = ^d;
      wait_clks(BIT_CLKS);
`endif
      rxd = stop_val;
      wait_clks(BIT_CLKS);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop_val);
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_clks(BIT_CLKS);
      end
      rxd = par;
      wait_clks(BIT_CLKS);
      rxd = stop_val;
      wait_clks(BIT_CLKS);
   endtask
`endif

   task automatic test_reset();
      reset    = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      wait_clks(3);
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      reset = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_single_byte();
      int         lat;
      logic [7:0] got;
      logic       valid_after;
      int         b_ovr, b_ferr, b_pop;
      b_ovr = ovr_cnt; b_ferr = ferr_cnt; b_pop = popq.size();
      rx_ready = 1'b1;
      lat = 0; got = 8'h00; valid_after = 1'bx;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (rx_valid !== 1'b1 && lat < 400) begin
               @(negedge clk);
               lat++;
            end
            got = rx_data;
            @(negedge clk);
            valid_after = rx_valid;
         end
      join
      wait_clks(BIT_CLKS);
      // rxd falls at N0; sync (2) + edge detect (1) + 8 start ticks + 9*16 ticks = 155 cycles.
      total++; if (lat !== 155) begin bad++; $display("FAIL t1_latency: got %0d want 155", lat); end
      total++; if (got !== 8'hA5) begin bad++; $display("FAIL t1_data: got %h want a5", got); end
      total++; if (valid_after !== 1'b0) begin bad++; $display("FAIL t1_valid_one_cycle: got %b want 0", valid_after); end
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t1_pops: got %0d want 1", popq.size() - b_pop); end
      total++; if (ovr_cnt - b_ovr !== 0) begin bad++; $display("FAIL t1_overrun: got %0d want 0", ovr_cnt - b_ovr); end
      total++; if (ferr_cnt - b_ferr !== 0) begin bad++; $display("FAIL t1_frame_err: got %0d want 0", ferr_cnt - b_ferr); end
   endtask

   task automatic test_overrun();
      int         b_ovr, b_pop;
      logic [7:0] exp;
      b_ovr = ovr_cnt; b_pop = popq.size();
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         exp = 8'(i);
         send_frame(exp, 1'b1);
      end
      wait_clks(BIT_CLKS);
      total++; if (ovr_cnt - b_ovr !== 1) begin bad++; $display("FAIL t2_overrun_count: got %0d want 1", ovr_cnt - b_ovr); end
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL t2_valid_full: got %b want 1", rx_valid); end
      total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL t2_head: got %h want 01", rx_data); end
      rx_ready = 1'b1;
      wait_clks(8);
      total++; if (popq.size() - b_pop !== 4) begin bad++; $display("FAIL t2_pop_count: got %0d want 4", popq.size() - b_pop); end
      if (popq.size() - b_pop >= 4) begin
         for (int k = 0; k < 4; k++) begin
            exp = 8'(k + 1);
            total++;
            if (popq[b_pop + k] !== exp) begin
               bad++; $display("FAIL t2_pop%0d: got %h want %h", k, popq[b_pop + k], exp);
            end
         end
      end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t2_empty: got %b want 0", rx_valid); end
   endtask

   task automatic test_break();
      int b_ferr, b_pop;
      b_ferr = ferr_cnt; b_pop = popq.size();
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      wait_clks(40 * BIT_CLKS);
      total++; if (ferr_cnt - b_ferr !== 1) begin bad++; $display("FAIL t3_frame_err_count: got %0d want 1", ferr_cnt - b_ferr); end
      total++; if (popq.size() - b_pop !== 0) begin bad++; $display("FAIL t3_no_push: got %0d want 0", popq.size() - b_pop); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t3_valid: got %b want 0", rx_valid); end
      rxd = 1'b1;
      wait_clks(2 * BIT_CLKS);
      send_frame(8'h55, 1'b1);
      wait_clks(BIT_CLKS);
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t3_next_pops: got %0d want 1", popq.size() - b_pop); end
      if (popq.size() - b_pop == 1) begin
         total++; if (popq[b_pop] !== 8'h55) begin bad++; $display("FAIL t3_next_data: got %h want 55", popq[b_pop]); end
      end
      total++; if (ferr_cnt - b_ferr !== 1) begin bad++; $display("FAIL t3_frame_err_after: got %0d want 1", ferr_cnt - b_ferr); end
   endtask

   task automatic test_glitch();
      int b_ferr, b_pop;
      b_ferr = ferr_cnt; b_pop = popq.size();
      rx_ready = 1'b1;
      rxd = 1'b0;
      wait_clks(4);
      rxd = 1'b1;
      wait_clks(3 * BIT_CLKS);
      total++; if (popq.size() - b_pop !== 0) begin bad++; $display("FAIL t4_no_push: got %0d want 0", popq.size() - b_pop); end
      total++; if (ferr_cnt - b_ferr !== 0) begin bad++; $display("FAIL t4_no_frame_err: got %0d want 0", ferr_cnt - b_ferr); end
      send_frame(8'h5A, 1'b1);
      wait_clks(BIT_CLKS);
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t4_next_pops: got %0d want 1", popq.size() - b_pop); end
      if (popq.size() - b_pop == 1) begin
         total++; if (popq[b_pop] !== 8'h5A) begin bad++; $display("FAIL t4_next_data: got %h want 5a", popq[b_pop]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int b_ferr, b_pop;
      b_ferr = ferr_cnt; b_pop = popq.size();
      rx_ready = 1'b1;
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      rxd = 1'b1;
      wait_clks(4 * BIT_CLKS + 8);
      reset = 1'b1;
      wait_clks(2);
      reset = 1'b0;
      wait_clks(6 * BIT_CLKS);
      total++; if (popq.size() - b_pop !== 0) begin bad++; $display("FAIL t5_no_push: got %0d want 0", popq.size() - b_pop); end
      total++; if (ferr_cnt - b_ferr !== 0) begin bad++; $display("FAIL t5_no_frame_err: got %0d want 0", ferr_cnt - b_ferr); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t5_valid: got %b want 0", rx_valid); end
      send_frame(8'h81, 1'b1);
      wait_clks(BIT_CLKS);
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t5_next_pops: got %0d want 1", popq.size() - b_pop); end
      if (popq.size() - b_pop == 1) begin
         total++; if (popq[b_pop] !== 8'h81) begin bad++; $display("FAIL t5_next_data: got %h want 81", popq[b_pop]); end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int b_ferr, b_pop;
      b_ferr = ferr_cnt; b_pop = popq.size();
      rx_ready = 1'b1;
      send_frame_par(8'h07, 1'b1, 1'b1);
      wait_clks(BIT_CLKS);
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t6_good_pops: got %0d want 1", popq.size() - b_pop); end
      if (popq.size() - b_pop == 1) begin
         total++; if (popq[b_pop] !== 8'h07) begin bad++; $display("FAIL t6_good_data: got %h want 07", popq[b_pop]); end
      end
      total++; if (ferr_cnt - b_ferr !== 0) begin bad++; $display("FAIL t6_good_frame_err: got %0d want 0", ferr_cnt - b_ferr); end
      send_frame_par(8'h07, 1'b0, 1'b1);
      wait_clks(BIT_CLKS);
      total++; if (ferr_cnt - b_ferr !== 1) begin bad++; $display("FAIL t6_bad_frame_err: got %0d want 1", ferr_cnt - b_ferr); end
      total++; if (popq.size() - b_pop !== 1) begin bad++; $display("FAIL t6_bad_no_push: got %0d want 1", popq.size() - b_pop); end
   endtask
`endif

   initial begin
      reset    = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_overrun();
      test_break();
      test_glitch();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
